// File: rtl/scdp_trace_buffer.sv
// scdp_trace_buffer: PC-triggered capture of SCDP debug taps into a first-word-fall-through FIFO
module scdp_trace_buffer #(
  parameter int DEPTH = 16,
  parameter logic [7:0] TRIG_PC = 8'h00,
  parameter int CAP_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     clear,
  input  logic [7:0]               pc_in,
  input  logic [3:0]               alu_in,
  input  logic [3:0]               rd_in,
  input  logic [3:0]               mem_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [19:0]              out_data,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [1:0]               state_out,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CAP_LEN + 1);
  localparam logic [CW-1:0] CAP = CW'(CAP_LEN);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURING, DONE} state_t;
  state_t state;
  logic [19:0] store [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic trig, push, pop, full, wr, drop;
  assign trig = state == ARMED && pc_in == TRIG_PC;
  assign push = trig || state == CAPTURING;
  assign full = fill == (AW+1)'(DEPTH);
  assign out_valid = fill != '0;
  assign pop = out_valid && out_ready;
  // a pop frees the slot the concurrent push needs, so a full FIFO still accepts
  assign wr = push && (!full || pop);
  assign drop = push && full && !pop;
  assign out_data = out_valid ? store[rptr] : '0;
  assign state_out = state;
  always_ff @(posedge clk)
    if (wr && !clear) store[wptr] <= {pc_in, alu_in, rd_in, mem_in};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
      cnt <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
      cnt <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wptr <= wptr + AW'(wr);
      rptr <= rptr + AW'(pop);
      fill <= fill + (AW+1)'(wr) - (AW+1)'(pop);
      overflow <= overflow | drop;
      drop_cnt <= drop_cnt + 8'(drop && drop_cnt != 8'hFF);
      if (trig) begin
        cnt <= CW'(1);
        state <= CAP_LEN == 1 ? DONE : CAPTURING;
      end else if (state == CAPTURING) begin
        cnt <= CW'(cnt + 1'b1);
        if (CW'(cnt + 1'b1) == CAP) state <= DONE;
      end else if (arm && (state == IDLE || state == DONE)) state <= ARMED;
    end
endmodule

// File: tb/tb_scdp_trace_buffer.sv
// tb_scdp_trace_buffer: directed checks over four parameterisations sharing one stimulus bus
module tb_scdp_trace_buffer;
  logic clk = 0, rst = 0, arm = 0, clear = 0, rdy = 0;
  logic [7:0] pc = 0;
  logic [3:0] alu = 0, rd = 0, md = 0;
  logic ov [4];
  logic [19:0] od [4];
  logic [4:0] fl [4];
  logic [1:0] st [4];
  logic of [4];
  logic [7:0] dc [4];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar i = 0; i < 4; i++) begin : g
    scdp_trace_buffer #(.DEPTH(16), .TRIG_PC(8'h08),
      .CAP_LEN(i == 0 ? 4 : i == 1 ? 20 : i == 2 ? 300 : 1)) u (
      .clk(clk), .rst(rst), .arm(arm), .clear(clear), .pc_in(pc), .alu_in(alu),
      .rd_in(rd), .mem_in(md), .out_valid(ov[i]), .out_ready(rdy), .out_data(od[i]),
      .fill(fl[i]), .state_out(st[i]), .overflow(of[i]), .drop_cnt(dc[i]));
  end
  function automatic logic [19:0] mk(input logic [7:0] p);
    return {p, p[5:2], 4'hA, 4'h5};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_pc(input logic [7:0] p);
    pc = p;
    alu = p[5:2];
    rd = 4'hA;
    md = 4'h5;
  endtask
  task automatic do_reset();
    rst = 0; arm = 0; clear = 0; rdy = 0;
    set_pc(0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    step();
  endtask
  task automatic run_seq();
    logic [7:0] s [7];
    s = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
    arm = 1; step(); arm = 0;
    for (int i = 0; i < 7; i++) begin set_pc(s[i]); step(); end
  endtask
  task automatic test_reset();
    rst = 0;
    #1;
    checks++; if (st[0] !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", st[0]); end
    checks++; if (fl[0] !== 5'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", fl[0]); end
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ov[0]); end
    checks++; if (of[0] !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", of[0]); end
    checks++; if (dc[0] !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", dc[0]); end
    checks++; if (od[0] !== 20'h0) begin errors++; $display("FAIL reset_data got %h want 0", od[0]); end
    do_reset();
  endtask
  task automatic test_capture();
    logic [7:0] e [4];
    e = '{8'h08, 8'h0C, 8'h10, 8'h14};
    do_reset();
    run_seq();
    checks++; if (st[0] !== 2'd3) begin errors++; $display("FAIL cap_state got %0d want 3", st[0]); end
    checks++; if (fl[0] !== 5'd4) begin errors++; $display("FAIL cap_fill got %0d want 4", fl[0]); end
    checks++; if (of[0] !== 1'b0) begin errors++; $display("FAIL cap_overflow got %b want 0", of[0]); end
    checks++; if (st[3] !== 2'd3) begin errors++; $display("FAIL cap1_state got %0d want 3", st[3]); end
    checks++; if (fl[3] !== 5'd1) begin errors++; $display("FAIL cap1_fill got %0d want 1", fl[3]); end
    set_pc(0);
    arm = 1; step(); arm = 0;
    checks++; if (st[0] !== 2'd1) begin errors++; $display("FAIL rearm_state got %0d want 1", st[0]); end
    checks++; if (fl[0] !== 5'd4) begin errors++; $display("FAIL rearm_fill got %0d want 4", fl[0]); end
    rdy = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (od[0] !== mk(e[i])) begin errors++; $display("FAIL cap_data%0d got %h want %h", i, od[0], mk(e[i])); end
      step();
    end
    rdy = 0;
    checks++; if (fl[0] !== 5'd0) begin errors++; $display("FAIL drain_fill got %0d want 0", fl[0]); end
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", ov[0]); end
    checks++; if (od[0] !== 20'h0) begin errors++; $display("FAIL drain_data got %h want 0", od[0]); end
  endtask
  task automatic test_empty_pop();
    do_reset();
    rdy = 1;
    step();
    checks++; if (fl[0] !== 5'd0) begin errors++; $display("FAIL empty_pop_fill got %0d want 0", fl[0]); end
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL empty_pop_valid got %b want 0", ov[0]); end
    arm = 1; step(); arm = 0;
    set_pc(8'h08); step();
    checks++; if (fl[0] !== 5'd1) begin errors++; $display("FAIL empty_pp_fill got %0d want 1", fl[0]); end
    checks++; if (od[0] !== mk(8'h08)) begin errors++; $display("FAIL empty_pp_data got %h want %h", od[0], mk(8'h08)); end
    set_pc(8'h0C); step();
    checks++; if (fl[0] !== 5'd1) begin errors++; $display("FAIL pp_fill got %0d want 1", fl[0]); end
    checks++; if (od[0] !== mk(8'h0C)) begin errors++; $display("FAIL pp_data got %h want %h", od[0], mk(8'h0C)); end
    rdy = 0;
  endtask
  task automatic test_overflow();
    do_reset();
    arm = 1; step(); arm = 0;
    for (int k = 0; k < 20; k++) begin set_pc(8'(8 + k)); step(); end
    checks++; if (st[1] !== 2'd3) begin errors++; $display("FAIL ovf_state got %0d want 3", st[1]); end
    checks++; if (fl[1] !== 5'd16) begin errors++; $display("FAIL ovf_fill got %0d want 16", fl[1]); end
    checks++; if (of[1] !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", of[1]); end
    checks++; if (dc[1] !== 8'd4) begin errors++; $display("FAIL ovf_drop got %0d want 4", dc[1]); end
    checks++; if (od[1] !== mk(8'h08)) begin errors++; $display("FAIL ovf_head got %h want %h", od[1], mk(8'h08)); end
  endtask
  task automatic test_full_passthrough();
    do_reset();
    arm = 1; step(); arm = 0;
    for (int k = 0; k < 16; k++) begin set_pc(8'(8 + k)); step(); end
    checks++; if (fl[1] !== 5'd16) begin errors++; $display("FAIL full_fill got %0d want 16", fl[1]); end
    rdy = 1;
    for (int k = 16; k < 20; k++) begin
      checks++; if (od[1] !== mk(8'(k - 8))) begin errors++; $display("FAIL pass_data%0d got %h want %h", k, od[1], mk(8'(k - 8))); end
      set_pc(8'(8 + k)); step();
      checks++; if (fl[1] !== 5'd16) begin errors++; $display("FAIL pass_fill%0d got %0d want 16", k, fl[1]); end
      checks++; if (dc[1] !== 8'd0) begin errors++; $display("FAIL pass_drop%0d got %0d want 0", k, dc[1]); end
    end
    checks++; if (st[1] !== 2'd3) begin errors++; $display("FAIL pass_state got %0d want 3", st[1]); end
    for (int j = 4; j < 20; j++) begin
      checks++; if (od[1] !== mk(8'(8 + j))) begin errors++; $display("FAIL pass_drain%0d got %h want %h", j, od[1], mk(8'(8 + j))); end
      step();
    end
    rdy = 0;
    checks++; if (fl[1] !== 5'd0) begin errors++; $display("FAIL pass_empty got %0d want 0", fl[1]); end
    checks++; if (of[1] !== 1'b0) begin errors++; $display("FAIL pass_overflow got %b want 0", of[1]); end
  endtask
  task automatic test_async_reset();
    do_reset();
    arm = 1; step(); arm = 0;
    set_pc(8'h08); step();
    set_pc(8'h0C); step();
    checks++; if (st[0] !== 2'd2) begin errors++; $display("FAIL mid_state got %0d want 2", st[0]); end
    checks++; if (fl[0] !== 5'd2) begin errors++; $display("FAIL mid_fill got %0d want 2", fl[0]); end
    #2 rst = 0;
    #1;
    checks++; if (st[0] !== 2'd0) begin errors++; $display("FAIL async_state got %0d want 0", st[0]); end
    checks++; if (fl[0] !== 5'd0) begin errors++; $display("FAIL async_fill got %0d want 0", fl[0]); end
    #2 rst = 1;
    step();
    run_seq();
    checks++; if (st[0] !== 2'd3) begin errors++; $display("FAIL recap_state got %0d want 3", st[0]); end
    checks++; if (fl[0] !== 5'd4) begin errors++; $display("FAIL recap_fill got %0d want 4", fl[0]); end
    checks++; if (od[0] !== mk(8'h08)) begin errors++; $display("FAIL recap_head got %h want %h", od[0], mk(8'h08)); end
  endtask
  task automatic test_clear_arm();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      arm = 1; step(); arm = 0;
      set_pc(8'h08); step();
      set_pc(8'h00);
    end
    checks++; if (st[3] !== 2'd3) begin errors++; $display("FAIL pre_clear_state got %0d want 3", st[3]); end
    checks++; if (fl[3] !== 5'd5) begin errors++; $display("FAIL pre_clear_fill got %0d want 5", fl[3]); end
    clear = 1; arm = 1; step(); clear = 0; arm = 0;
    checks++; if (st[3] !== 2'd0) begin errors++; $display("FAIL clear_state got %0d want 0", st[3]); end
    checks++; if (fl[3] !== 5'd0) begin errors++; $display("FAIL clear_fill got %0d want 0", fl[3]); end
    checks++; if (of[3] !== 1'b0) begin errors++; $display("FAIL clear_overflow got %b want 0", of[3]); end
  endtask
  task automatic test_saturate();
    do_reset();
    arm = 1; step(); arm = 0;
    for (int k = 0; k < 300; k++) begin set_pc(8'(8 + k)); step(); end
    checks++; if (dc[2] !== 8'd255) begin errors++; $display("FAIL sat_drop got %0d want 255", dc[2]); end
    checks++; if (of[2] !== 1'b1) begin errors++; $display("FAIL sat_overflow got %b want 1", of[2]); end
    checks++; if (st[2] !== 2'd3) begin errors++; $display("FAIL sat_state got %0d want 3", st[2]); end
    checks++; if (fl[2] !== 5'd16) begin errors++; $display("FAIL sat_fill got %0d want 16", fl[2]); end
    clear = 1; step(); clear = 0;
    checks++; if (dc[2] !== 8'd0) begin errors++; $display("FAIL sat_clear_drop got %0d want 0", dc[2]); end
    checks++; if (of[2] !== 1'b0) begin errors++; $display("FAIL sat_clear_overflow got %b want 0", of[2]); end
    checks++; if (fl[2] !== 5'd0) begin errors++; $display("FAIL sat_clear_fill got %0d want 0", fl[2]); end
  endtask
  initial begin
    test_reset();
    test_capture();
    test_empty_pop();
    test_overflow();
    test_full_passthrough();
    test_async_reset();
    test_clear_arm();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/scdp_trace_buffer.md
SCDP_TRACE_BUFFER -- requirements
Module: scdp_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16: FIFO entries; SHALL be a power of two.
REQ-002 Parameter TRIG_PC, default 8'h00: PC value that starts a capture.
REQ-003 Parameter CAP_LEN, default 16: samples per capture window, legal range 1..255.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 arm  input  1  single-cycle pulse: arm the trigger.
REQ-007 clear  input  1  synchronous: flush FIFO, clear flags, return to IDLE.
REQ-008 pc_in  input  8  datapath PC debug value, from SCDP pc_out_debug.
REQ-009 alu_in  input  4  from SCDP alu_result_out.
REQ-010 rd_in  input  4  from SCDP regfile_rd_out.
REQ-011 mem_in  input  4  from SCDP data_memory_out.
REQ-012 out_valid  output  1  FIFO non-empty.
REQ-013 out_ready  input  1  consumer accepts the head entry.
REQ-014 out_data  output  20  head entry, packed as {pc, alu, rd, mem}.
REQ-015 fill  output  log2(DEPTH)+1  current occupancy.
REQ-016 state_out  output  2  IDLE=0, ARMED=1, CAPTURING=2, DONE=3.
REQ-017 overflow  output  1  sticky: at least one sample was dropped.
REQ-018 drop_cnt  output  8  dropped-sample count, saturates at 255.

Function
REQ-019 IDLE: arm=1 SHALL move the FSM to ARMED the next cycle; no samples SHALL be pushed.
REQ-020 ARMED, on a cycle with pc_in==TRIG_PC:
- that cycle's sample SHALL be pushed
- the sample counter SHALL be set to 1
- the FSM SHALL move to CAPTURING.
REQ-021 CAPTURING: one sample SHALL be pushed every cycle and the counter incremented.
REQ-022 CAPTURING: the FSM SHALL move to DONE on the edge where the counter reaches CAP_LEN.
- A capture SHALL therefore produce exactly CAP_LEN push attempts.
REQ-023 CAP_LEN=1: the trigger cycle SHALL go directly ARMED->DONE.
REQ-024 DONE: no samples SHALL be pushed; arm SHALL re-enter ARMED without flushing the FIFO.
REQ-025 arm in ARMED or CAPTURING SHALL be ignored.
REQ-026 clear SHALL take priority over arm, push and pop in the same cycle:
- fill, overflow, drop_cnt and the counter go to 0
- the FSM goes to IDLE.
REQ-027 Pop SHALL occur when out_valid && out_ready.
- out_data SHALL be the oldest entry (first-word-fall-through, no read latency).
REQ-028 out_ready with the FIFO empty SHALL have no effect.
REQ-029 A push attempt with the FIFO full and no pop in the same cycle:
- the sample SHALL be dropped and FIFO contents left unchanged
- overflow SHALL be set and drop_cnt incremented (saturating)
- the sample counter SHALL still increment.
REQ-030 Push and pop in the same cycle with the FIFO full:
- both SHALL succeed and fill SHALL remain DEPTH
- no drop SHALL be recorded.
REQ-031 Push and pop in the same cycle with the FIFO empty:
- the pop SHALL be ignored, the push accepted, and fill SHALL become 1
- the new entry SHALL appear on out_data the next cycle.
REQ-032 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
- fill SHALL distinguish full (DEPTH) from empty (0).
REQ-033 Inputs SHALL be sampled unregistered on the push edge; no input SHALL combinationally affect any output except through registered state.

Reset
REQ-034 With rst low, these SHALL be forced immediately, independent of clk:
- state_out=0, fill=0, out_valid=0, overflow=0, drop_cnt=0
- the pointers and counter to 0.
REQ-035 out_data SHALL be 20'h0 while the FIFO is empty after reset; FIFO storage SHALL NOT need a reset.
REQ-036 A reset asserted during CAPTURING SHALL abort the capture.
- Operation SHALL resume in IDLE after rst is released, with the FIFO empty.

Verification
REQ-037 TRIG_PC=8'h08, CAP_LEN=4, out_ready=0, arm pulse, pc_in stepping 0,4,8,C,10,14,18:
- required: 4 entries pushed, with PCs 08,0C,10,14
- required: state_out=3, fill=4, overflow=0.
REQ-038 DEPTH=16, CAP_LEN=20, out_ready=0:
- required: fill=16, overflow=1, drop_cnt=4, state DONE
- required: the head entry is the trigger-cycle sample.
REQ-039 Full FIFO, CAPTURING, out_ready=1 continuously:
- required: fill stays 16 every cycle and drop_cnt stays unchanged
- required: entries emerge in push order.
REQ-040 rst driven low mid-capture, asynchronously between clock edges:
- required: state_out=0 and fill=0 before the next rising edge.
- required: after release, a new arm plus trigger captures correctly.
REQ-041 clear and arm asserted in the same cycle while in DONE with fill=5:
- required: next cycle state IDLE, fill=0, overflow=0.
REQ-042 CAP_LEN=300, DEPTH=16 (long overflow, with CAP_LEN overridden outside its legal range for this test only):
- required: drop_cnt saturates at 255 and overflow remains 1.
